// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the core's single data-memory port between the
//               pipeline load/store path (absolute priority, no stall) and a
//               secondary bus master whose requests wait in a 2-entry FIFO.
//               Read data is returned to both sides; sec_rvalid marks the
//               cycles that carry a secondary read result.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,

  // Pipeline side
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_rdata,

  // Secondary master side
  input  logic        sec_valid,
  output logic        sec_ready,
  input  logic        sec_we,
  input  logic [31:0] sec_addr,
  input  logic [31:0] sec_wdata,
  input  logic [3:0]  sec_sign_mask,
  output logic        sec_rvalid,
  output logic [31:0] sec_rdata,

  // Data memory side
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata,

  output logic        starve
);

  localparam logic [1:0] c_FIFO_FULL  = 2'd2;
  localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_LIMIT);

  // FIFO storage: one slot per pointer value
  logic        r_fifo_we   [2];
  logic [31:0] r_fifo_addr [2];
  logic [31:0] r_fifo_wdata[2];
  logic [3:0]  r_fifo_mask [2];

  // FIFO control and response/starvation state
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic        r_rd_owner_sec;
  logic [7:0]  r_starve_cnt;

  // Combinational decode
  logic        w_cpu_busy;
  logic        w_fifo_empty;
  logic        w_push;
  logic        w_issue;
  logic        w_head_we;
  logic [31:0] w_head_addr;
  logic [31:0] w_head_wdata;
  logic [3:0]  w_head_mask;

  assign w_cpu_busy   = cpu_memread | cpu_memwrite;
  assign w_fifo_empty = (r_count == 2'd0);

  // Ready depends only on registered count; a full FIFO never bypasses,
  // even if the head pops in the same cycle.
  assign sec_ready    = (r_count != c_FIFO_FULL);
  assign w_push       = sec_valid & sec_ready;

  // The secondary only gets the port in cycles the pipeline leaves idle.
  assign w_issue      = ~w_cpu_busy & ~w_fifo_empty;

  assign w_head_we    = r_fifo_we[r_rd_ptr];
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_wdata = r_fifo_wdata[r_rd_ptr];
  assign w_head_mask  = r_fifo_mask[r_rd_ptr];

  // Read data is broadcast; each side ignores data it did not request.
  assign cpu_rdata    = mem_rdata;
  assign sec_rdata    = mem_rdata;
  assign sec_rvalid   = r_rd_owner_sec;

  assign starve       = (r_starve_cnt == c_STARVE_MAX);

  // Port mux: pipeline passthrough, else FIFO head, else all zero
  always_comb begin
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_memwrite  = 1'b0;
    mem_memread   = 1'b0;
    mem_sign_mask = 4'h0;
    if (w_cpu_busy) begin
      mem_addr      = cpu_addr;
      mem_wdata     = cpu_wdata;
      mem_memwrite  = cpu_memwrite;
      mem_memread   = cpu_memread;
      mem_sign_mask = cpu_sign_mask;
    end else if (w_issue) begin
      mem_addr      = w_head_addr;
      mem_wdata     = w_head_wdata;
      mem_memwrite  = w_head_we;
      mem_memread   = ~w_head_we;
      mem_sign_mask = w_head_mask;
    end
  end

  // FIFO payload write; contents need no reset because count gates them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_we[r_wr_ptr]    <= sec_we;
      r_fifo_addr[r_wr_ptr]  <= sec_addr;
      r_fifo_wdata[r_wr_ptr] <= sec_wdata;
      r_fifo_mask[r_wr_ptr]  <= sec_sign_mask;
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop keeps count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_issue) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_issue) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_issue) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // Remember that the read presented this cycle belongs to the secondary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner_sec <= 1'b0;
    end else begin
      r_rd_owner_sec <= w_issue & ~w_head_we;
    end
  end

  // Count consecutive cycles a queued request is held off by the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 8'd0;
    end else if (w_issue || w_fifo_empty) begin
      r_starve_cnt <= 8'd0;
    end else if (w_cpu_busy && (r_starve_cnt != c_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter. A behavioural data
//               memory answers reads one cycle later; expected secondary read
//               data is queued when the request is driven and popped when
//               sec_rvalid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  localparam int c_STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_rdata;
  logic        sec_valid;
  logic        sec_ready;
  logic        sec_we;
  logic [31:0] sec_addr;
  logic [31:0] sec_wdata;
  logic [3:0]  sec_sign_mask;
  logic        sec_rvalid;
  logic [31:0] sec_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata = 32'h0;
  logic        starve;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];
  logic [31:0] mem_model [logic [31:0]];

  dmem_port_arbiter #(.STARVE_LIMIT(c_STARVE_LIMIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_memread   (cpu_memread),
    .cpu_sign_mask (cpu_sign_mask),
    .cpu_rdata     (cpu_rdata),
    .sec_valid     (sec_valid),
    .sec_ready     (sec_ready),
    .sec_we        (sec_we),
    .sec_addr      (sec_addr),
    .sec_wdata     (sec_wdata),
    .sec_sign_mask (sec_sign_mask),
    .sec_rvalid    (sec_rvalid),
    .sec_rdata     (sec_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_sign_mask (mem_sign_mask),
    .mem_rdata     (mem_rdata),
    .starve        (starve)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: writes land at the edge, reads return next cycle
  always @(posedge clk) begin
    if (mem_memwrite) mem_model[mem_addr] = mem_wdata;
    if (mem_memread) mem_rdata <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
  end

  // Scoreboard: every secondary read result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sec_rvalid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_rvalid: sec_rvalid=1 rdata=%h, no read outstanding", sec_rdata);
      end else begin
        logic [31:0] exp_d;
        exp_d = sb_q.pop_front();
        if (sec_rdata !== exp_d) begin
          n_fail++;
          $display("FAIL sb_rdata: got %h expected %h", sec_rdata, exp_d);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
    cpu_sign_mask = 4'h0;
    sec_valid = 1'b0; sec_we = 1'b0; sec_addr = 32'h0; sec_wdata = 32'h0; sec_sign_mask = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    to_sample();
    n_checks++; if (sec_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", sec_ready); end
    n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", sec_rvalid); end
    n_checks++; if (starve !== 1'b0) begin n_fail++; $display("FAIL reset_starve: got %b expected 0", starve); end
    n_checks++;
    if ({mem_memread, mem_memwrite, mem_addr, mem_wdata, mem_sign_mask} !== 70'h0) begin
      n_fail++; $display("FAIL reset_mem_outputs: rd=%b wr=%b addr=%h wd=%h mask=%h expected all 0",
                         mem_memread, mem_memwrite, mem_addr, mem_wdata, mem_sign_mask);
    end
    n_checks++; if (cpu_rdata !== mem_rdata) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h expected %h", cpu_rdata, mem_rdata); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_idle_read();
    mem_model[32'h100] = 32'hDEADBEEF;
    sec_valid = 1'b1; sec_we = 1'b0; sec_addr = 32'h100; sec_sign_mask = 4'hF;
    to_sample();
    n_checks++; if (sec_ready !== 1'b1) begin n_fail++; $display("FAIL idle_read_ready: got %b expected 1", sec_ready); end
    sb_q.push_back(32'hDEADBEEF);
    next_cycle();
    sec_valid = 1'b0;
    to_sample();
    n_checks++; if (mem_memread !== 1'b1 || mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL idle_read_strobe: rd=%b wr=%b expected rd=1 wr=0", mem_memread, mem_memwrite); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL idle_read_addr: got %h expected 00000100", mem_addr); end
    n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_read_early_rvalid: got %b expected 0", sec_rvalid); end
    next_cycle();
    to_sample();
    n_checks++; if (sec_rvalid !== 1'b1) begin n_fail++; $display("FAIL idle_read_rvalid: got %b expected 1", sec_rvalid); end
    n_checks++; if (sec_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_read_data: got %h expected deadbeef", sec_rdata); end
    n_checks++; if (mem_memread !== 1'b0) begin n_fail++; $display("FAIL idle_read_single_issue: rd=%b expected 0", mem_memread); end
    next_cycle();
    to_sample();
    n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_read_rvalid_pulse: got %b expected 0", sec_rvalid); end
    next_cycle();
  endtask

  task automatic test_cpu_priority();
    for (int c = 0; c < 10; c++) begin
      cpu_memread = 1'b1; cpu_addr = 32'h200 + c; cpu_wdata = 32'hC0DE0000 + c;
      cpu_sign_mask = 4'(c);
      if (c < 2) begin
        sec_valid = 1'b1; sec_we = 1'b1; sec_addr = 32'h300 + c;
        sec_wdata = 32'hA5A50000 + c; sec_sign_mask = 4'h3;
      end else begin
        sec_valid = 1'b0;
      end
      to_sample();
      n_checks++;
      if (mem_memread !== 1'b1 || mem_memwrite !== 1'b0 || mem_addr !== cpu_addr ||
          mem_wdata !== cpu_wdata || mem_sign_mask !== cpu_sign_mask) begin
        n_fail++; $display("FAIL prio_passthrough[%0d]: rd=%b wr=%b addr=%h wd=%h mask=%h expected rd=1 wr=0 addr=%h wd=%h mask=%h",
                           c, mem_memread, mem_memwrite, mem_addr, mem_wdata, mem_sign_mask, cpu_addr, cpu_wdata, cpu_sign_mask);
      end
      n_checks++;
      if (sec_ready !== (c < 2)) begin n_fail++; $display("FAIL prio_ready[%0d]: got %b expected %b", c, sec_ready, (c < 2)); end
      next_cycle();
    end
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      to_sample();
      n_checks++;
      if (mem_memwrite !== 1'b1 || mem_memread !== 1'b0 || mem_addr !== 32'h300 + k ||
          mem_wdata !== 32'hA5A50000 + k || mem_sign_mask !== 4'h3) begin
        n_fail++; $display("FAIL prio_drain[%0d]: wr=%b rd=%b addr=%h wd=%h mask=%h expected wr=1 rd=0 addr=%h wd=%h mask=3",
                           k, mem_memwrite, mem_memread, mem_addr, mem_wdata, mem_sign_mask, 32'h300 + k, 32'hA5A50000 + k);
      end
      n_checks++;
      if (sec_ready !== (k == 1)) begin n_fail++; $display("FAIL prio_drain_ready[%0d]: got %b expected %b", k, sec_ready, (k == 1)); end
      next_cycle();
    end
    to_sample();
    n_checks++; if (mem_memwrite !== 1'b0 || mem_memread !== 1'b0) begin n_fail++; $display("FAIL prio_drained: wr=%b rd=%b expected 0 0", mem_memwrite, mem_memread); end
    next_cycle();
  endtask

  task automatic test_starvation();
    mem_model[32'h500] = 32'h55AA55AA;
    cpu_memwrite = 1'b1; cpu_addr = 32'h900; cpu_wdata = 32'h1;
    sec_valid = 1'b1; sec_we = 1'b0; sec_addr = 32'h500; sec_sign_mask = 4'hF;
    to_sample();
    n_checks++; if (starve !== 1'b0) begin n_fail++; $display("FAIL starve_initial: got %b expected 0", starve); end
    sb_q.push_back(32'h55AA55AA);
    next_cycle();
    sec_valid = 1'b0;
    // In blocked cycle k the counter holds k-1, so it reaches the limit
    // once c_STARVE_LIMIT blocked cycles have completed.
    for (int k = 1; k <= 7; k++) begin
      to_sample();
      n_checks++;
      if (starve !== ((k - 1) >= c_STARVE_LIMIT)) begin
        n_fail++; $display("FAIL starve_blocked[%0d]: got %b expected %b", k, starve, ((k - 1) >= c_STARVE_LIMIT));
      end
      n_checks++;
      if (mem_memwrite !== 1'b1 || mem_addr !== 32'h900) begin n_fail++; $display("FAIL starve_cpu_owns[%0d]: wr=%b addr=%h expected wr=1 addr=00000900", k, mem_memwrite, mem_addr); end
      next_cycle();
    end
    cpu_memwrite = 1'b0;
    to_sample();
    n_checks++; if (mem_memread !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL starve_issue: rd=%b addr=%h expected rd=1 addr=00000500", mem_memread, mem_addr); end
    n_checks++; if (starve !== 1'b1) begin n_fail++; $display("FAIL starve_at_issue: got %b expected 1", starve); end
    next_cycle();
    to_sample();
    n_checks++; if (starve !== 1'b0) begin n_fail++; $display("FAIL starve_cleared: got %b expected 0", starve); end
    n_checks++; if (sec_rvalid !== 1'b1) begin n_fail++; $display("FAIL starve_rvalid: got %b expected 1", sec_rvalid); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_full_fifo();
    cpu_memread = 1'b1; cpu_addr = 32'h900;
    for (int c = 0; c < 5; c++) begin
      sec_valid = 1'b1; sec_we = 1'b1; sec_addr = 32'h600 + c;
      sec_wdata = 32'hF0F00000 + c; sec_sign_mask = 4'hF;
      to_sample();
      n_checks++;
      if (sec_ready !== (c < 2)) begin n_fail++; $display("FAIL full_ready[%0d]: got %b expected %b", c, sec_ready, (c < 2)); end
      next_cycle();
    end
    cpu_memread = 1'b0;
    sec_addr = 32'h605; sec_wdata = 32'hF0F00005;
    to_sample();
    n_checks++; if (mem_memwrite !== 1'b1 || mem_addr !== 32'h600 || mem_wdata !== 32'hF0F00000) begin
      n_fail++; $display("FAIL full_pop0: wr=%b addr=%h wd=%h expected wr=1 addr=00000600 wd=f0f00000", mem_memwrite, mem_addr, mem_wdata);
    end
    n_checks++; if (sec_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %b expected 0", sec_ready); end
    next_cycle();
    sec_valid = 1'b0;
    to_sample();
    n_checks++; if (sec_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b expected 1", sec_ready); end
    n_checks++; if (mem_memwrite !== 1'b1 || mem_addr !== 32'h601 || mem_wdata !== 32'hF0F00001) begin
      n_fail++; $display("FAIL full_pop1: wr=%b addr=%h wd=%h expected wr=1 addr=00000601 wd=f0f00001", mem_memwrite, mem_addr, mem_wdata);
    end
    next_cycle();
    to_sample();
    n_checks++; if (mem_memwrite !== 1'b0 || mem_memread !== 1'b0) begin n_fail++; $display("FAIL full_drained: wr=%b rd=%b expected 0 0", mem_memwrite, mem_memread); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    // No scoreboard entry: this read's response must be lost to reset.
    sec_valid = 1'b1; sec_we = 1'b0; sec_addr = 32'h100; sec_sign_mask = 4'hF;
    to_sample();
    n_checks++; if (sec_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept: got %b expected 1", sec_ready); end
    next_cycle();
    sec_valid = 1'b0;
    to_sample();
    n_checks++; if (mem_memread !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL rstmid_issue: rd=%b addr=%h expected rd=1 addr=00000100", mem_memread, mem_addr); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_memread !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_drop: rd=%b expected 0", mem_memread); end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      if (k == 1) rst_n = 1'b1;
      to_sample();
      n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid[%0d]: got %b expected 0", k, sec_rvalid); end
      n_checks++; if (sec_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready[%0d]: got %b expected 1", k, sec_ready); end
      n_checks++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobes[%0d]: rd=%b wr=%b expected 0 0", k, mem_memread, mem_memwrite); end
    end
    n_checks++; if (starve !== 1'b0) begin n_fail++; $display("FAIL rstmid_starve: got %b expected 0", starve); end
    next_cycle();
  endtask

  task automatic test_write_then_read();
    mem_model[32'h40] = 32'hFFFFFFFF;
    cpu_memread = 1'b1; cpu_addr = 32'h900;
    sec_valid = 1'b1; sec_we = 1'b1; sec_addr = 32'h40; sec_wdata = 32'h12345678; sec_sign_mask = 4'hF;
    to_sample();
    n_checks++; if (sec_ready !== 1'b1) begin n_fail++; $display("FAIL wr_rd_accept_w: got %b expected 1", sec_ready); end
    next_cycle();
    sec_we = 1'b0; sec_wdata = 32'h0;
    to_sample();
    n_checks++; if (sec_ready !== 1'b1) begin n_fail++; $display("FAIL wr_rd_accept_r: got %b expected 1", sec_ready); end
    sb_q.push_back(32'h12345678);
    next_cycle();
    idle_inputs();
    to_sample();
    n_checks++; if (mem_memwrite !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL wr_rd_write: wr=%b addr=%h wd=%h expected wr=1 addr=00000040 wd=12345678", mem_memwrite, mem_addr, mem_wdata);
    end
    next_cycle();
    to_sample();
    n_checks++; if (mem_memread !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL wr_rd_read: rd=%b addr=%h expected rd=1 addr=00000040", mem_memread, mem_addr); end
    next_cycle();
    to_sample();
    n_checks++; if (sec_rvalid !== 1'b1 || sec_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL wr_rd_result: rvalid=%b data=%h expected rvalid=1 data=12345678", sec_rvalid, sec_rdata);
    end
    next_cycle();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_idle_read();
    test_cpu_priority();
    test_starvation();
    test_full_fifo();
    test_reset_mid_read();
    test_write_then_read();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
